// File: rtl/act_unit_vec_pkg.sv
// act_unit_vec_pkg: shared mode codes and saturation / clip helpers for act_unit_vec.
package act_pkg;
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_LEAKY = 2'd2;
  localparam logic [1:0] MODE_CLIP  = 2'd3;
  function automatic int sat_to_width(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
  function automatic int clip_ceiling(input int clip_int, input int frac, input int data_w);
    return sat_to_width(clip_int << frac, data_w);
  endfunction
endpackage

// File: rtl/act_unit_vec_if.sv
// act_unit_vec_if: input/output beat streams of act_unit_vec.
//   master: drives in_valid/in_data/mode/alpha and out_ready (upstream + downstream side)
//   slave : the activation stage; drives in_ready, out_valid, out_data
interface act_unit_vec_if #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 8,
  parameter int ALPHA_W = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [1:0]                mode;
  logic [ALPHA_W-1:0]        alpha;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  modport master (
    output in_valid, in_data, mode, alpha, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, mode, alpha, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/act_unit_vec_lane.sv
// act_lane: one activation lane; S1 captures sign/product/mode/sample, S2 rounds, saturates and selects.
//   clk, rst : clock, async active-high reset
//   ld1, ld2 : stage load enables from the shared handshake control
//   x, mode, alpha : lane sample and per-beat configuration
//   y        : registered result
//   sat      : registered "this lane saturated" flag (only with ACT_UNIT_SAT_STATS_EN)
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ALPHA_W  = 8,
  parameter int ALPHA_SH = 4,
  parameter int CLIP     = 96
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld1,
  input  logic               ld2,
  input  logic [DATA_W-1:0]  x,
  input  logic [1:0]         mode,
  input  logic [ALPHA_W-1:0] alpha,
  output logic [DATA_W-1:0]  y
`ifdef ACT_UNIT_SAT_STATS_EN
  ,
  output logic               sat
`endif
);
  localparam int P    = DATA_W + ALPHA_W;
  localparam int HALF = (1 << ALPHA_SH) >> 1;
  logic signed [P-1:0] prod;
  logic                s1_neg;
  logic signed [P-1:0] s1_prod;
  logic [1:0]          s1_mode;
  logic [DATA_W-1:0]   s1_x;
  int                  r;
  int                  lk;
  logic [DATA_W-1:0]   y_n;
  // |x*alpha| < 2^(P-1), so the P-bit signed product never wraps
  assign prod = P'($signed(x) * $signed({1'b0, alpha}));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_neg  <= 1'b0;
      s1_prod <= '0;
      s1_mode <= MODE_PASS;
      s1_x    <= '0;
    end else if (ld1) begin
      s1_neg  <= x[DATA_W-1];
      s1_prod <= prod;
      s1_mode <= mode;
      s1_x    <= x;
    end
  assign r  = (int'(s1_prod) + HALF) >>> ALPHA_SH;
  assign lk = sat_to_width(r, DATA_W);
  always_comb
    y_n = (s1_mode == MODE_PASS) ? s1_x :
          s1_neg ? ((s1_mode == MODE_LEAKY) ? DATA_W'(lk) : '0) :
          ((s1_mode == MODE_CLIP) && ($signed(s1_x) > CLIP)) ? DATA_W'(CLIP) : s1_x;
  always_ff @(posedge clk or posedge rst)
    if (rst) y <= '0;
    else if (ld2) y <= y_n;
`ifdef ACT_UNIT_SAT_STATS_EN
  logic sat_n;
  assign sat_n = (s1_mode == MODE_LEAKY) && s1_neg && (lk != r);
  always_ff @(posedge clk or posedge rst)
    if (rst) sat <= 1'b0;
    else if (ld2) sat <= sat_n;
`endif
endmodule

// File: rtl/act_unit_vec.sv
// act_unit_vec: LANES-wide two-stage activation (pass/ReLU/leaky/clipped ReLU) with valid/ready.
//   clk, rst  : clock, async active-high reset
//   bus       : act_unit_vec_if.slave (in_valid/in_ready/in_data/mode/alpha, out_valid/out_ready/out_data)
//   sat_count : lanes saturated in delivered beats, sticky at 16'hFFFF;
//               counts only when ACT_UNIT_SAT_STATS_EN is defined, otherwise tied to 0
module act_unit_vec
  import act_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int FRAC     = 4,
  parameter int ALPHA_W  = 8,
  parameter int ALPHA_SH = 4,
  parameter int CLIP_INT = 6
) (
  input  logic               clk,
  input  logic               rst,
  act_unit_vec_if.slave      bus,
  output logic [15:0]        sat_count
);
  localparam int CLIP = clip_ceiling(CLIP_INT, FRAC, DATA_W);
  logic                    s1_valid;
  logic                    adv2;
  logic                    ld1;
  logic                    ld2;
  logic [LANES*DATA_W-1:0] y_all;
  logic [LANES-1:0]        sat;
  // S2 can take a new beat when empty or draining this cycle; S1 likewise when S2 advances
  assign adv2         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv2;
  assign ld1          = bus.in_valid && bus.in_ready;
  assign ld2          = adv2 && s1_valid;
  assign bus.out_data = y_all;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (adv2) bus.out_valid <= s1_valid;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_W  (DATA_W),
      .ALPHA_W (ALPHA_W),
      .ALPHA_SH(ALPHA_SH),
      .CLIP    (CLIP)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .ld1  (ld1),
      .ld2  (ld2),
      .x    (bus.in_data[i*DATA_W +: DATA_W]),
      .mode (bus.mode),
      .alpha(bus.alpha),
      .y    (y_all[i*DATA_W +: DATA_W])
`ifdef ACT_UNIT_SAT_STATS_EN
      ,
      .sat  (sat[i])
`endif
    );
  end
`ifdef ACT_UNIT_SAT_STATS_EN
  logic [16:0] sum;
  assign sum = 17'(sat_count) + 17'($countones(sat));
  always_ff @(posedge clk or posedge rst)
    if (rst) sat_count <= '0;
    else if (bus.out_valid && bus.out_ready) sat_count <= sum[16] ? 16'hFFFF : sum[15:0];
`else
  assign sat       = '0;
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_act_unit_vec.sv
// tb_act_unit_vec: scoreboard bench for act_unit_vec with a plain-arithmetic reference model.
module tb_act_unit_vec;
  localparam int LANES = 4, DW = 8, FRAC = 4, AW = 8, SH = 4, CI = 6;
  logic        clk = 0;
  logic        rst = 0;
  logic [15:0] sat_count;
  act_unit_vec_if #(.LANES(LANES), .DATA_W(DW), .ALPHA_W(AW)) bus();
  act_unit_vec #(
    .LANES(LANES), .DATA_W(DW), .FRAC(FRAC), .ALPHA_W(AW), .ALPHA_SH(SH), .CLIP_INT(CI)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] d;
    int          acc;
    int          ns;
  } exp_t;
  exp_t        q[$];
  int          compared = 0, mismatched = 0, cyc = 0, exp_sat = 0, blk_depth = -1;
  bit          chk_lat = 0, seen_head = 0, prev_stall = 0, rand_rdy = 0, saw_in_block = 0;
  logic [31:0] prev_data;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask
  function automatic logic [31:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction
  // Reference: spec arithmetic with integer floor division instead of shifts
  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m,
                                        input logic [7:0] a, output int ns);
    logic [31:0] res;
    logic [7:0]  s;
    int x, y, num, quo, clip, hi, lo;
    hi   = 2 ** (DW - 1) - 1;
    lo   = -(2 ** (DW - 1));
    clip = CI * (2 ** FRAC);
    if (clip > hi) clip = hi;
    ns = 0;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      s = d[i*DW +: DW];
      x = int'($signed(s));
      case (m)
        2'd0: y = x;
        2'd1: y = (x < 0) ? 0 : x;
        2'd2: begin
          if (x >= 0) y = x;
          else begin
            num = x * int'(a) + 2 ** (SH - 1);
            quo = num / (2 ** SH);
            if ((num % (2 ** SH) != 0) && (num < 0)) quo = quo - 1;
            if (quo > hi) begin quo = hi; ns++; end
            if (quo < lo) begin quo = lo; ns++; end
            y = quo;
          end
        end
        default: y = (x < 0) ? 0 : (x > clip ? clip : x);
      endcase
      res[i*DW +: DW] = 8'(y);
    end
    return res;
  endfunction
  // Monitor: samples on the falling edge, i.e. the values that the next rising edge will act on
  always @(negedge clk) begin
    exp_t e;
    int   ns;
    if (rst) begin
      seen_head  = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && !seen_head) begin
        seen_head = 1;
        if (chk_lat && q.size() > 0) check("latency", 32'(cyc - q[0].acc), 2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("out_with_empty_queue", 32'(q.size()), 1);
        else begin
          e = q.pop_front();
          check("out_data", bus.out_data, e.d);
          exp_sat = (exp_sat + e.ns > 65535) ? 65535 : exp_sat + e.ns;
        end
        seen_head = 0;
      end
      if (!bus.in_ready && !saw_in_block) begin
        saw_in_block = 1;
        blk_depth    = q.size();
      end
      if (bus.in_valid && bus.in_ready) begin
        e.d   = model(bus.in_data, bus.mode, bus.alpha, ns);
        e.acc = cyc;
        e.ns  = ns;
        q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end
  always @(posedge clk) if (rand_rdy) begin
    #1 bus.out_ready = ($urandom % 10) < 7;
  end
  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [7:0] a);
    int n = 0;
    bus.in_valid = 1;
    bus.in_data  = d;
    bus.mode     = m;
    bus.alpha    = a;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask
  int sat4_exp;
  initial begin
`ifdef ACT_UNIT_SAT_STATS_EN
    sat4_exp = 4;
`else
    sat4_exp = 0;
`endif
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.mode      = 2'd0;
    bus.alpha     = '0;
    bus.out_ready = 1;
    #1 rst = 1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_sat_count", sat_count, 0);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1 check("rst_in_ready", bus.in_ready, 1);
    chk_lat = 1;
    send(pack(-16, -3, -2, 50), 2'd2, 8'd4);
    drain();
    send(pack(100, 127, 96, -5), 2'd3, 8'd0);
    send(pack(100, 127, 96, -5), 2'd1, 8'd0);
    send(pack(100, 127, 96, -5), 2'd0, 8'd0);
    drain();
    send(pack(-128, -128, -128, -128), 2'd2, 8'd255);
    drain();
    check("sat_count_after_sat_beat", sat_count, sat4_exp);
    for (int k = 0; k < 4; k++)
      send(pack(-16, -16, -16, -16), (k % 2 == 0) ? 2'd2 : 2'd1, (k % 2 == 0) ? 8'd8 : 8'd0);
    drain();
    chk_lat      = 0;
    saw_in_block = 0;
    fork
      for (int k = 0; k < 8; k++) send($urandom, 2'($urandom), 8'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    check("in_ready_dropped", saw_in_block, 1);
    check("buffered_at_block", 32'(blk_depth), 2);
    bus.out_ready = 0;
    send(pack(1, 2, 3, 4), 2'd0, 8'd0);
    send(pack(5, 6, 7, 8), 2'd0, 8'd0);
    #2 rst = 1;
    q.delete();
    exp_sat = 0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_sat_count", sat_count, 0);
    @(posedge clk);
    #3 rst = 0;
    bus.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_beat", bus.out_valid, 0);
    end
    @(posedge clk);
    #1 chk_lat = 1;
    send(pack(-16, 20, -1, 127), 2'd2, 8'd16);
    drain();
    chk_lat  = 0;
    rand_rdy = 1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 send($urandom, 2'($urandom), 8'($urandom));
    end
    drain();
    rand_rdy = 0;
    #5 bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
`ifdef ACT_UNIT_SAT_STATS_EN
    check("final_sat_count", sat_count, exp_sat);
`else
    check("final_sat_count", sat_count, 0);
`endif
    check("final_queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
